// File: rtl/sign_operation_resolver_if.sv
// rtl/sign_operation_resolver_if.sv - operand/result handshake bundle for sign_operation_resolver
interface sign_operation_resolver_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Data_X;
  logic [W-1:0] Data_Y;
  logic         add_subt;
  logic [1:0]   r_mode;
  logic         out_valid;
  logic         out_ready;
  logic         real_op;
  logic         swap_op;
  logic         sign_result;
  logic         zero_result;

  modport slave (
    input  in_valid, Data_X, Data_Y, add_subt, r_mode, out_ready,
    output in_ready, out_valid, real_op, swap_op, sign_result, zero_result
  );

  modport master (
    output in_valid, Data_X, Data_Y, add_subt, r_mode, out_ready,
    input  in_ready, out_valid, real_op, swap_op, sign_result, zero_result
  );
endinterface

// File: rtl/sign_operation_resolver.sv
// rtl/sign_operation_resolver.sv - FPU add/sub sign, swap and effective-op decision, 2-stage pipeline
// Optional: SIGN_ZERO_RM_EN makes an exact-zero difference take its sign from r_mode.
module sign_operation_resolver #(
  parameter int W  = 32,
  parameter int EW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sign_operation_resolver_if.slave bus
);
  localparam int SW = W - 1 - EW;

  logic         s1_valid;
  logic         s1_adv;
  logic         accept;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_y;
  logic         s1_sub;
`ifdef SIGN_ZERO_RM_EN
  logic [1:0]   s1_rm;
`else
  logic         unused_rm;
  assign unused_rm = ^bus.r_mode;
`endif

  assign s1_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_sub   <= 1'b0;
`ifdef SIGN_ZERO_RM_EN
      s1_rm    <= 2'b00;
`endif
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_x     <= bus.Data_X;
      s1_y     <= bus.Data_Y;
      s1_sub   <= bus.add_subt;
`ifdef SIGN_ZERO_RM_EN
      s1_rm    <= bus.r_mode;
`endif
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  logic         sx;
  logic         sye;
  logic         equal_sgn;
  logic         gt;
  logic         eq;
  logic         zero_sign;
  logic         d_real;
  logic         d_zero;
  logic         d_sign;
  logic [W-2:0] mag_x;
  logic [W-2:0] mag_y;

  // Exponent above significand, so a plain unsigned compare orders magnitudes.
  always_comb begin
    mag_x     = {s1_x[W-2 -: EW], s1_x[SW-1:0]};
    mag_y     = {s1_y[W-2 -: EW], s1_y[SW-1:0]};
    sx        = s1_x[W-1];
    sye       = s1_y[W-1] ^ s1_sub;
    equal_sgn = (sx == sye);
    gt        = (mag_y > mag_x);
    eq        = (mag_y == mag_x);
    d_real    = !equal_sgn;
    d_zero    = d_real && eq;
`ifdef SIGN_ZERO_RM_EN
    zero_sign = (s1_rm == 2'b10);
`else
    zero_sign = 1'b0;
`endif
    if (equal_sgn)   d_sign = sx;
    else if (d_zero) d_sign = zero_sign;
    else if (gt)     d_sign = sye;
    else             d_sign = sx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.real_op     <= 1'b0;
      bus.swap_op     <= 1'b0;
      bus.sign_result <= 1'b0;
      bus.zero_result <= 1'b0;
    end else if (s1_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.real_op     <= d_real;
        bus.swap_op     <= gt;
        bus.sign_result <= d_sign;
        bus.zero_result <= d_zero;
      end
    end
  end
endmodule
